// File: rtl/store_merge_unit.sv
// Purpose: selects one of N_SRC store-data sources and issues word/half/byte stores;
//          subword stores merge into the memory word by read-modify-write.
// Latency: word store 2 cycles start->done; subword MEM_LAT+3; error pulse in cycle 1.
// Backpressure: start is taken only in IDLE; caller stalls on busy until done/err.
// Optional: define STORE_MERGE_BYTEEN_EN for byte-enable stores (adds mem_be, no RMW).
module store_merge_unit #(
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 1,
  parameter int MEM_LAT = 1,
  localparam int N_SRC  = 2**SEL_W,
  localparam int NB     = DATA_W/8,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SEL_W-1:0]        src_sel,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [1:0]              size,
  input  logic [OFF_W-1:0]        addr_lo,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_we,
  output logic                    mem_re,
  output logic                    busy,
  output logic                    done,
  output logic                    err
`ifdef STORE_MERGE_BYTEEN_EN
  ,
  output logic [NB-1:0]           mem_be
`endif
);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [3:0]          cnt_q;
  logic [15:0]         data_q;
  logic [1:0]          size_q;
  logic [OFF_W-1:0]    off_q;
  logic [DATA_W-1:0]   sel_data;
  logic [DATA_W-1:0]   merged;
  logic                bad_req;
  logic                accept;
`ifdef STORE_MERGE_BYTEEN_EN
  logic [NB-1:0]       be_q;
`endif

  // Reserved size, or a halfword that would straddle an odd byte, is rejected.
  assign bad_req = (size == SZ_RSVD) || ((size == SZ_HALF) && addr_lo[0]);
  assign accept  = (state_q == S_IDLE) && start;

  // Source mux: source i lives at bits [i*DATA_W +: DATA_W].
  always_comb begin
    sel_data = src_data[DATA_W-1:0];
    for (int i = 0; i < N_SRC; i++) begin
      if (src_sel == SEL_W'(i)) sel_data = src_data[i*DATA_W +: DATA_W];
    end
  end

  // Little-endian lane merge of the captured store data into the read word.
  always_comb begin
    merged = mem_rdata;
    for (int i = 0; i < NB; i++) begin
      if ((size_q == SZ_BYTE) && (off_q == OFF_W'(i)))
        merged[8*i +: 8] = data_q[7:0];
      if ((size_q == SZ_HALF) && (off_q == OFF_W'(i)))
        merged[8*i +: 8] = data_q[7:0];
      if ((size_q == SZ_HALF) && ((off_q + OFF_W'(1)) == OFF_W'(i)))
        merged[8*i +: 8] = data_q[15:8];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; subword stores go through READ/WAIT unless byte enables exist.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad_req)                state_d = S_ERR;
          else if (size == SZ_WORD)   state_d = S_WRITE;
          else begin
`ifdef STORE_MERGE_BYTEEN_EN
                                      state_d = S_WRITE;
`else
                                      state_d = S_READ;
`endif
          end
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded straight from state, so reset drops them immediately.
  always_comb begin
    busy   = (state_q != S_IDLE);
    mem_re = (state_q == S_READ);
    mem_we = (state_q == S_WRITE);
    done   = (state_q == S_DONE);
    err    = (state_q == S_ERR);
`ifdef STORE_MERGE_BYTEEN_EN
    mem_be = (state_q == S_WRITE) ? be_q : '0;
`endif
  end

  // Capture on accept, latency countdown, and write-data update (capture or merge only).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      data_q    <= '0;
      size_q    <= 2'b00;
      off_q     <= '0;
      mem_wdata <= '0;
`ifdef STORE_MERGE_BYTEEN_EN
      be_q      <= '0;
`endif
    end else begin
      if (accept) begin
        data_q <= sel_data[15:0];
        size_q <= size;
        off_q  <= addr_lo;
        if (!bad_req) begin
          if (size == SZ_WORD) mem_wdata <= sel_data;
`ifdef STORE_MERGE_BYTEEN_EN
          else if (size == SZ_BYTE) mem_wdata <= {NB{sel_data[7:0]}};
          else                      mem_wdata <= {(NB/2){sel_data[15:0]}};
          if (size == SZ_WORD)      be_q <= '1;
          else if (size == SZ_BYTE) be_q <= NB'(1) << addr_lo;
          else                      be_q <= NB'(3) << addr_lo;
`endif
        end
      end
      if (state_q == S_READ) cnt_q <= 4'(MEM_LAT - 1);
      if (state_q == S_WAIT) begin
        if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        else               mem_wdata <= merged;
      end
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Purpose: randomized and directed bench for store_merge_unit against a lane-arithmetic model.
// Latency: checks exact write/done/err cycles relative to the start edge.
// Backpressure: pulses start while busy and in the done cycle; those must be ignored.
module tb_store_merge_unit;

  localparam int DATA_W  = 32;
  localparam int SEL_W   = 1;
  localparam int MEM_LAT = 3;
  localparam int OFF_W   = 2;
  localparam int N_SRC   = 2;

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic [SEL_W-1:0]        src_sel;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [1:0]              size;
  logic [OFF_W-1:0]        addr_lo;
  logic [DATA_W-1:0]       mem_rdata;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_we;
  logic                    mem_re;
  logic                    busy;
  logic                    done;
  logic                    err;

  int checks = 0;
  int errors = 0;

  // Memory model: the addressed word is visible only MEM_LAT cycles after the read strobe.
  logic [31:0]        mem_word;
  logic [31:0]        junk;
  logic [MEM_LAT-1:0] rpipe;

  store_merge_unit #(
    .DATA_W  (DATA_W),
    .SEL_W   (SEL_W),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_sel   (src_sel),
    .src_data  (src_data),
    .size      (size),
    .addr_lo   (addr_lo),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) rpipe <= '0;
    else       rpipe <= {rpipe[MEM_LAT-2:0], mem_re};
  end

  always @(posedge clk) junk <= $urandom;

  assign mem_rdata = rpipe[MEM_LAT-1] ? mem_word : junk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: what the addressed memory word must look like after the store.
  function automatic logic [31:0] ref_store(input logic [1:0] sz, input int off,
                                            input logic [31:0] data, input logic [31:0] mw);
    logic [31:0] mask;
    mask = 32'h0;
    if (sz == 2'b00) return data;
    if (sz == 2'b01) mask = 32'h0000FFFF << (8*off);
    if (sz == 2'b10) mask = 32'h000000FF << (8*off);
    return (mw & ~mask) | ((data << (8*off)) & mask);
  endfunction

  task automatic run_store(input string tag, input logic sel, input logic [31:0] s0,
                           input logic [31:0] s1, input logic [1:0] sz, input int off,
                           input logic [31:0] mw);
    logic [31:0] data;
    logic [31:0] exp;
    logic [31:0] we_dat;
    bit          is_err;
    int          we_n, we_cyc, re_n, re_cyc, done_n, done_cyc, err_n, err_cyc;
    data   = sel ? s1 : s0;
    is_err = (sz == 2'b11) || (sz == 2'b01 && (off % 2) == 1);
    exp    = ref_store(sz, off, data, mw);
    we_n = 0; we_cyc = -1; re_n = 0; re_cyc = -1;
    done_n = 0; done_cyc = -1; err_n = 0; err_cyc = -1; we_dat = 32'h0;

    @(negedge clk);
    src_sel  = sel;
    src_data = {s1, s0};
    size     = sz;
    addr_lo  = OFF_W'(off);
    mem_word = mw;
    start    = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (mem_we) begin we_n++; we_cyc = cyc; we_dat = mem_wdata; end
      if (mem_re) begin re_n++; re_cyc = cyc; end
      if (done)   begin done_n++; done_cyc = cyc; end
      if (err)    begin err_n++; err_cyc = cyc; end
      // Inputs change after the start edge; start is re-pulsed while busy and on done.
      src_data = {$urandom, $urandom};
      size     = 2'($urandom);
      addr_lo  = OFF_W'($urandom);
      src_sel  = SEL_W'($urandom);
      start    = (cyc == 1) || done;
      @(negedge clk);
    end
    start = 1'b0;

    check($sformatf("%s.busy_end", tag), 32'(busy), 32'd0);
    if (is_err) begin
      check($sformatf("%s.err_n", tag), err_n, 1);
      check($sformatf("%s.err_cyc", tag), err_cyc, 1);
      check($sformatf("%s.we_n", tag), we_n, 0);
      check($sformatf("%s.re_n", tag), re_n, 0);
      check($sformatf("%s.done_n", tag), done_n, 0);
    end else begin
      check($sformatf("%s.err_n", tag), err_n, 0);
      check($sformatf("%s.we_n", tag), we_n, 1);
      check($sformatf("%s.done_n", tag), done_n, 1);
      check($sformatf("%s.wdata", tag), we_dat, exp);
      if (sz == 2'b00) begin
        check($sformatf("%s.re_n", tag), re_n, 0);
        check($sformatf("%s.we_cyc", tag), we_cyc, 1);
        check($sformatf("%s.done_cyc", tag), done_cyc, 2);
      end else begin
        check($sformatf("%s.re_n", tag), re_n, 1);
        check($sformatf("%s.re_cyc", tag), re_cyc, 1);
        check($sformatf("%s.we_cyc", tag), we_cyc, MEM_LAT + 2);
        check($sformatf("%s.done_cyc", tag), done_cyc, MEM_LAT + 3);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    reset    = 1'b1;
    start    = 1'b0;
    src_sel  = '0;
    src_data = '0;
    size     = 2'b00;
    addr_lo  = '0;
    mem_word = 32'h0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.we", 32'(mem_we), 32'd0);
    check("rst.re", 32'(mem_re), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run_store("word", 1'b1, 32'h12345678, 32'hDEADBEEF, 2'b00, 0, 32'h0);
    run_store("byte", 1'b0, 32'h000000AB, 32'hFFFFFFFF, 2'b10, 2, 32'h11223344);
    run_store("half", 1'b0, 32'h0000CAFE, 32'h0, 2'b01, 2, 32'h11223344);
    run_store("err_half_odd", 1'b0, 32'h0000CAFE, 32'h0, 2'b01, 1, 32'h11223344);
    run_store("err_rsvd", 1'b1, 32'h0, 32'h55555555, 2'b11, 0, 32'h11223344);
    run_store("byte_hi", 1'b1, 32'h0, 32'h000000EE, 2'b10, 3, 32'hA5A5A5A5);

    // Reset asserted while waiting for read data aborts the store.
    @(negedge clk);
    src_sel  = 1'b0;
    src_data = {32'h0, 32'h000000AB};
    size     = 2'b10;
    addr_lo  = 2'd1;
    mem_word = 32'h11223344;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort.busy_pre", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.we", 32'(mem_we), 32'd0);
    check("abort.re", 32'(mem_re), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_we || mem_re || done || busy) stray++;
    end
    check("abort.no_activity", stray, 0);

    run_store("after_abort", 1'b1, 32'h0, 32'hCAFEF00D, 2'b00, 1, 32'h0);

    for (int n = 0; n < 40; n++) begin
      run_store($sformatf("rnd%0d", n), 1'($urandom), $urandom, $urandom,
                2'($urandom), int'($urandom_range(0, 3)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
Parametrised successor to the 2:1 memory write-data select. It selects one of N_SRC store-data sources and performs word, halfword and byte stores. Subword stores use a read-modify-write sequence on the memory port. It sits between the register/word-craft datapath and data memory. The control unit starts it and stalls on busy until done.

Parameters:
DATA_W, 32, memory word width in bits; must be a multiple of 8 and at least 16
SEL_W, 1, source-select width; N_SRC = 2**SEL_W
MEM_LAT, 1, memory read latency in cycles, from the mem_re cycle to valid mem_rdata; legal range 1..15
OFF_W, log2(DATA_W/8), byte-offset width (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
src_sel  in  SEL_W  source index, captured on start
src_data  in  N_SRC*DATA_W  packed sources; source i is bits [i*DATA_W +: DATA_W] (source 0 = B register, source 1 = word-craft value)
size  in  2  00 word, 01 half, 10 byte, 11 reserved; captured on start
addr_lo  in  OFF_W  byte offset within word; captured on start
mem_rdata  in  DATA_W  memory read data
mem_wdata  out  DATA_W  registered write data
mem_we  out  1  write strobe, one cycle per store
mem_re  out  1  read strobe, one cycle per subword store
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse; no write is issued

Behaviour:
- Reset (asynchronous, active-high) forces IDLE. All outputs go to 0, internal captures go to 0 and the latency counter clears. A reset asserted mid-operation aborts it, and no mem_we is issued afterward.
- States: IDLE, READ, WAIT, WRITE, DONE, ERR.
- IDLE: if start=1, capture sel=src_sel, data=src_data[sel], size and addr_lo, then branch:
  - size=11, or size=01 with addr_lo[0]=1: go to ERR.
  - size=00: go to WRITE with mem_wdata=data. addr_lo is ignored for word stores.
  - size=01 or 10: go to READ.
- READ: mem_re=1 for exactly one cycle; load the counter with MEM_LAT-1; go to WAIT.
- WAIT: stay until the counter reaches 0, decrementing each cycle. On the edge leaving WAIT, merge mem_rdata into mem_wdata:
  - Byte stores replace bits [8*addr_lo +: 8] with data[7:0].
  - Half stores replace bits [8*addr_lo +: 16] with data[15:0].
  - All other bits come from mem_rdata.
  - Byte order is little-endian.
- WRITE: mem_we=1 for one cycle; go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- ERR: err=1 for one cycle; go to IDLE. mem_we and mem_re stay 0 throughout.
- Latency from the start edge to the done cycle:
  - Word store: 2 cycles (WRITE in cycle 1, DONE in cycle 2).
  - Subword store: MEM_LAT+3 cycles.
  - Error: err is high in cycle 1.
- start is ignored while busy=1. start asserted in a DONE or ERR cycle is also ignored; it is accepted only once the block is back in IDLE.
- src_data, size and addr_lo may change after the start edge without effect. The caller holds the memory address stable while busy=1.
- mem_wdata holds its last value in IDLE and changes only on capture or merge.
- An out-of-range src_sel cannot occur, since N_SRC = 2**SEL_W.

Optional Feature:
Macro STORE_MERGE_BYTEEN_EN.
- When defined:
  - An extra output mem_be [DATA_W/8] is added.
  - Subword stores skip READ and WAIT and go from IDLE straight to WRITE.
  - mem_wdata carries data[7:0] (byte) or data[15:0] (half) replicated across all lanes.
  - mem_be has 1 only on the targeted lanes; word stores drive mem_be all ones.
  - mem_be is 0 outside WRITE and on reset.
  - Subword latency becomes 2 cycles, and mem_re is never asserted.
- When undefined: mem_be does not exist and the read-modify-write behaviour above applies.

Test Plan:
- Word store: src_data = {32'hDEADBEEF, 32'h12345678}, src_sel=1, size=00, start for 1 cycle -> mem_we=1 in cycle 1 with mem_wdata=DEADBEEF; done in cycle 2; mem_re never asserted.
- Byte store: src_sel=0, data 0x000000AB, addr_lo=2, MEM_LAT=1, mem_rdata=0x11223344 -> mem_re in cycle 1; mem_we in cycle 3 with 0x11AB3344; done in cycle 4.
- Half store with MEM_LAT=3: data 0x0000CAFE, addr_lo=2, mem_rdata=0x11223344 -> mem_we in cycle 5 with 0xCAFE3344.
- Errors: size=01 with addr_lo=1, and separately size=11 -> err=1 in cycle 1; mem_we and mem_re stay 0; done never asserted.
- Reset and restart: assert reset during WAIT -> busy, mem_we, mem_re and done drop to 0 immediately with no later write. Then start pulses issued while busy -> ignored, with exactly one done per accepted start.
- With STORE_MERGE_BYTEEN_EN defined: byte store of 0xAB at addr_lo=3 -> mem_wdata=0xABABABAB, mem_be=4'b1000 in cycle 1, done in cycle 2, mem_re=0.
